// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port word memory.
// One transaction in flight at a time; the memory returns read data one cycle after READ.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m0_cmd,
    input  logic [8:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ready,
    output logic [15:0] m0_rdata,
    input  logic [1:0]  m1_cmd,
    input  logic [8:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ready,
    output logic [15:0] m1_rdata,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        owner,
    output logic        busy
);
    // state  | meaning
    // IDLE   | waiting for a request, arbitration happens only here
    // ACCESS | latched command driven to memory for one cycle
    // RDWAIT | memory read data returned to the owner
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      state;
    logic        last_grant;
    logic [1:0]  lat_cmd;
    logic [8:0]  lat_addr;
    logic [15:0] lat_wdata;

    logic req0, req1, grant, done;

    assign req0 = (m0_cmd == CMD_READ) || (m0_cmd == CMD_WRITE);
    assign req1 = (m1_cmd == CMD_READ) || (m1_cmd == CMD_WRITE);

    // On a tie the master that did not win last time gets the grant.
    assign grant = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_cmd    <= CMD_NONE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= grant;
                        last_grant <= grant;
                        lat_cmd    <= grant ? m1_cmd   : m0_cmd;
                        lat_addr   <= grant ? m1_addr  : m0_addr;
                        lat_wdata  <= grant ? m1_wdata : m0_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS:  state <= (lat_cmd == CMD_READ) ? RDWAIT : IDLE;
                RDWAIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_cmd   = (state == ACCESS) ? lat_cmd   : CMD_NONE;
    assign mem_addr  = (state == ACCESS) ? lat_addr  : '0;
    assign mem_wdata = (state == ACCESS) ? lat_wdata : '0;

    assign done = ((state == ACCESS) && (lat_cmd == CMD_WRITE)) || (state == RDWAIT);

    assign m0_ready = done && !owner;
    assign m1_ready = done && owner;
    assign m0_rdata = (m0_ready && (state == RDWAIT)) ? mem_rdata : '0;
    assign m1_rdata = (m1_ready && (state == RDWAIT)) ? mem_rdata : '0;

endmodule
